pwm_capture: RTL and testbench
==============================

# pwm_capture

Downstream measurement stage for the PWM generator. It samples an asynchronous PWM waveform and measures its period and high time, in `Clk_In` cycles, rising edge to rising edge. Each completed period is published through a valid/ready handshake. The block flags a stuck-high or stuck-low line and any dropped measurement. It provides closed-loop checking of the generator output and capture of external PWM inputs.

## Interface
- `CNT_WIDTH`, default 32: width of the cycle counter and of the measurement outputs.
- `SYNC_STAGES`, default 2 (minimum 2): number of synchronizer flops on `PWM_Signal_In`.
- `Clk_In` in 1: single clock, rising edge.
- `Reset_n_In` in 1: reset, asynchronous assert, active-low.
- `Capture_Enable_In` in 1: run when high; when low, abort and clear.
- `PWM_Signal_In` in 1: asynchronous PWM input.
- `Timeout_Cycles_In` in CNT_WIDTH: stuck-line threshold; 0 disables the timeout.
- `Measure_Ready_In` in 1: consumer accepts the current measurement.
- `Measure_Valid_Out` out 1: a measurement is pending.
- `Period_Cycles_Out` out CNT_WIDTH: rise-to-rise cycle count.
- `High_Cycles_Out` out CNT_WIDTH: rise-to-fall cycle count.
- `Stuck_High_Out` out 1: line high for at least the timeout.
- `Stuck_Low_Out` out 1: line low for at least the timeout.
- `Overrun_Out` out 1: sticky; a measurement was dropped.

## Operation
- **Reset:** all outputs are 0, the counter is 0, and the FSM is in IDLE.
- **Edge detection:** `PWM_Signal_In` passes through SYNC_STAGES flops, then one `prev` flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - `prev` always tracks sync, independent of enable, so a line already high at enable is not a rise.
- **FSM states:** IDLE, ARM, HIGH, LOW.
- **IDLE:** entered whenever `Capture_Enable_In` = 0. Counter, valid, data and all flags are cleared. Moves to ARM when enable = 1.
- **ARM:**
  - Counter increments each cycle.
  - Fall is ignored.
  - On rise: counter loads 1 and the FSM moves to HIGH. Nothing is published, because the first rise only arms.
- **HIGH:**
  - Counter increments.
  - On fall: latch High = counter, then move to LOW.
- **LOW:**
  - Counter increments.
  - On rise: publish Period = counter and High = latched value, load counter with 1, and move to HIGH.
- **Resulting values:** for H synchronized high cycles and L low cycles, Period = H+L and High = H. The minimum measurable H and L are each 1 cycle.
- **Counter saturation:** the counter holds at 2^CNT_WIDTH−1 instead of wrapping.
- **Timeout:**
  - If `Timeout_Cycles_In` ≠ 0 and counter == timeout in ARM, HIGH or LOW, set Stuck_High when sync = 1, otherwise Stuck_Low.
  - From HIGH or LOW the FSM moves to ARM with the counter held.
  - Both stuck flags clear on the next detected edge.
- **Handshake:**
  - Valid is held with data stable until valid & ready at a clock edge; valid then clears the next cycle.
  - If a publish coincides with acceptance, the new data loads, valid stays 1 and no overrun is raised.
  - If a publish occurs while valid = 1 and ready = 0, the new data is dropped, the old data is kept and `Overrun_Out` is set. Overrun clears only in IDLE or on reset.
- **Enable deassert mid-measurement:** the measurement is aborted with no partial publish, and the FSM goes to IDLE the next cycle.

## Timing
- Latency from input transition to register update: an input rise sampled at edge k is seen as sync = 1 after edge k+SYNC_STAGES−1. Rise is detected in that cycle, and `Measure_Valid_Out` rises at edge k+SYNC_STAGES.
- Stuck flag latency: flags assert the cycle after counter == timeout.
- All outputs are registered, with no combinational path from any input to any output.
- Reset assertion is asynchronous at any time; all state returns to reset values immediately. Deassertion is assumed synchronized upstream.

## Structure
- Package `pwm_pkg` holds:
  - the FSM state typedef: IDLE, ARM, HIGH, LOW;
  - the default CNT_WIDTH and SYNC_STAGES constants, shared with the generator.
- Sub-module `pwm_sync_edge`: the synchronizer chain plus `prev` flop, producing sync, rise and fall.

## Test plan
- Input high 30 / low 70 cycles repeating, `Measure_Ready_In` = 1: the first valid appears after the second rise, and every measurement reads Period = 100, High = 30.
- Timeout = 500, input held low after enable: `Stuck_Low_Out` = 1 at counter = 500 with no valid. A later rise clears the flag, and the first period after that publishes correctly.
- Ready = 0 for three periods of 10 / 10: first data Period = 20, High = 10 is held and `Overrun_Out` = 1. Ready pulsed for one cycle: valid clears the next cycle and Overrun stays 1.
- CNT_WIDTH = 8, timeout = 0, input high 300 / low 10: High = 255 and Period = 255 (saturated).
- `Capture_Enable_In` dropped mid-HIGH, then re-enabled: no publish occurs, all flags clear, and the first measurement after re-arm is correct.
- `Reset_n_In` pulsed low mid-LOW: outputs go to 0 asynchronously and the FSM restarts in IDLE.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and FSM state encoding for the PWM generator/capture family.
package pwm_pkg;

    localparam int unsigned PWM_CNT_WIDTH   = 32;
    localparam int unsigned PWM_SYNC_STAGES = 2;

    typedef logic [1:0] pwm_state_t;

    localparam pwm_state_t ST_IDLE = 2'd0;
    localparam pwm_state_t ST_ARM  = 2'd1;
    localparam pwm_state_t ST_HIGH = 2'd2;
    localparam pwm_state_t ST_LOW  = 2'd3;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizes an asynchronous PWM line and flags rising/falling edges of the synchronized level.
module pwm_sync_edge
    import pwm_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = PWM_SYNC_STAGES
) (
    input  logic Clk_In,
    input  logic Reset_n_In,
    input  logic PWM_Signal_In,
    output logic Sync_Out,
    output logic Rise_Out_c,
    output logic Fall_Out_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // prev follows the synchronized level unconditionally so a line already high at enable is no edge
    always_ff @(posedge Clk_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], PWM_Signal_In};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign Sync_Out   = sync_q[SYNC_STAGES-1];
    assign Rise_Out_c = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign Fall_Out_c = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time rise-to-rise and publishes each period over valid/ready,
// flagging stuck lines and dropped measurements.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = PWM_CNT_WIDTH,
    parameter int unsigned SYNC_STAGES = PWM_SYNC_STAGES
) (
    input  logic                 Clk_In,
    input  logic                 Reset_n_In,
    input  logic                 Capture_Enable_In,
    input  logic                 PWM_Signal_In,
    input  logic [CNT_WIDTH-1:0] Timeout_Cycles_In,
    input  logic                 Measure_Ready_In,
    output logic                 Measure_Valid_Out,
    output logic [CNT_WIDTH-1:0] Period_Cycles_Out,
    output logic [CNT_WIDTH-1:0] High_Cycles_Out,
    output logic                 Stuck_High_Out,
    output logic                 Stuck_Low_Out,
    output logic                 Overrun_Out
);

    logic sync;
    logic rise_c;
    logic fall_c;

    pwm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .Clk_In        (Clk_In),
        .Reset_n_In    (Reset_n_In),
        .PWM_Signal_In (PWM_Signal_In),
        .Sync_Out      (sync),
        .Rise_Out_c    (rise_c),
        .Fall_Out_c    (fall_c)
    );

    pwm_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] high_lat_q, high_lat_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;
    logic                 valid_q, valid_d;
    logic                 stuck_hi_q, stuck_hi_d;
    logic                 stuck_lo_q, stuck_lo_d;
    logic                 ovr_q, ovr_d;

    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 timeout_hit;
    logic                 publish;

    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign timeout_hit = (Timeout_Cycles_In != '0) && (cnt_q == Timeout_Cycles_In);

    always_ff @(posedge Clk_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            high_lat_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            stuck_hi_q <= 1'b0;
            stuck_lo_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_lat_q <= high_lat_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            stuck_hi_q <= stuck_hi_d;
            stuck_lo_q <= stuck_lo_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_lat_d = high_lat_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = valid_q;
        stuck_hi_d = stuck_hi_q;
        stuck_lo_d = stuck_lo_q;
        ovr_d      = ovr_q;
        publish    = 1'b0;

        if (!Capture_Enable_In) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            high_lat_d = '0;
            period_d   = '0;
            high_d     = '0;
            valid_d    = 1'b0;
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
            ovr_d      = 1'b0;
        end else begin
            if (valid_q && Measure_Ready_In) begin
                valid_d = 1'b0;
            end
            if ((rise_c || fall_c) && (state_q != ST_IDLE)) begin
                stuck_hi_d = 1'b0;
                stuck_lo_d = 1'b0;
            end

            // Edges take priority over the timeout in the same cycle
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    cnt_d = cnt_inc;
                    if (rise_c) begin
                        cnt_d   = CNT_WIDTH'(1);
                        state_d = ST_HIGH;
                    end else if (timeout_hit) begin
                        stuck_hi_d = sync | stuck_hi_q;
                        stuck_lo_d = ~sync | stuck_lo_q;
                    end
                end
                ST_HIGH: begin
                    cnt_d = cnt_inc;
                    if (fall_c) begin
                        high_lat_d = cnt_q;
                        state_d    = ST_LOW;
                    end else if (timeout_hit) begin
                        stuck_hi_d = sync | stuck_hi_q;
                        stuck_lo_d = ~sync | stuck_lo_q;
                        cnt_d      = cnt_q;
                        state_d    = ST_ARM;
                    end
                end
                ST_LOW: begin
                    cnt_d = cnt_inc;
                    if (rise_c) begin
                        publish = 1'b1;
                        cnt_d   = CNT_WIDTH'(1);
                        state_d = ST_HIGH;
                    end else if (timeout_hit) begin
                        stuck_hi_d = sync | stuck_hi_q;
                        stuck_lo_d = ~sync | stuck_lo_q;
                        cnt_d      = cnt_q;
                        state_d    = ST_ARM;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // A pending, unaccepted measurement is kept and the new one dropped
            if (publish) begin
                if (!valid_q || Measure_Ready_In) begin
                    period_d = cnt_q;
                    high_d   = high_lat_q;
                    valid_d  = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    assign Measure_Valid_Out = valid_q;
    assign Period_Cycles_Out = period_q;
    assign High_Cycles_Out   = high_q;
    assign Stuck_High_Out    = stuck_hi_q;
    assign Stuck_Low_Out     = stuck_lo_q;
    assign Overrun_Out       = ovr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: a 32-bit instance and an 8-bit instance for saturation.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        en8;
    logic        pwm;
    logic        ready;
    logic [31:0] timeout;
    logic [7:0]  timeout8;

    logic        valid, stk_hi, stk_lo, ovr;
    logic [31:0] period, high;
    logic        valid8, stk_hi8, stk_lo8, ovr8;
    logic [7:0]  period8, high8;

    int n_checks = 0;
    int n_fail   = 0;

    longint unsigned got_p[$], got_h[$], exp_p[$], exp_h[$];
    longint unsigned got8_p[$], got8_h[$];

    pwm_capture u_dut (
        .Clk_In            (clk),
        .Reset_n_In        (rst_n),
        .Capture_Enable_In (en),
        .PWM_Signal_In     (pwm),
        .Timeout_Cycles_In (timeout),
        .Measure_Ready_In  (ready),
        .Measure_Valid_Out (valid),
        .Period_Cycles_Out (period),
        .High_Cycles_Out   (high),
        .Stuck_High_Out    (stk_hi),
        .Stuck_Low_Out     (stk_lo),
        .Overrun_Out       (ovr)
    );

    pwm_capture #(
        .CNT_WIDTH   (8),
        .SYNC_STAGES (2)
    ) u_dut8 (
        .Clk_In            (clk),
        .Reset_n_In        (rst_n),
        .Capture_Enable_In (en8),
        .PWM_Signal_In     (pwm),
        .Timeout_Cycles_In (timeout8),
        .Measure_Ready_In  (ready),
        .Measure_Valid_Out (valid8),
        .Period_Cycles_Out (period8),
        .High_Cycles_Out   (high8),
        .Stuck_High_Out    (stk_hi8),
        .Stuck_Low_Out     (stk_lo8),
        .Overrun_Out       (ovr8)
    );

    always #5 clk = ~clk;

    // Reference: a period of H high and L low cycles reads Period = H+L, High = H, saturating at 2^w-1
    function automatic longint unsigned sat(input longint unsigned x, input int unsigned w);
        longint unsigned m;
        m = (64'd1 << w) - 64'd1;
        return (x > m) ? m : x;
    endfunction

    task automatic add_period(input int unsigned h, input int unsigned l, input int unsigned w);
        exp_p.push_back(sat(longint'(h) + longint'(l), w));
        exp_h.push_back(sat(longint'(h), w));
    endtask

    task automatic clear_q();
        got_p.delete(); got_h.delete(); got8_p.delete(); got8_h.delete();
        exp_p.delete(); exp_h.delete();
    endtask

    // One clock: drive the level, record accepted measurements at the falling edge, return 1ns after the rise
    task automatic step(input logic lvl);
        pwm = lvl;
        @(negedge clk);
        if (valid && ready) begin
            got_p.push_back(longint'(period));
            got_h.push_back(longint'(high));
        end
        if (valid8 && ready) begin
            got8_p.push_back(longint'(period8));
            got8_h.push_back(longint'(high8));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic lvl, input int n);
        repeat (n) step(lvl);
    endtask

    task automatic drive_period(input int unsigned h, input int unsigned l, input int unsigned w);
        hold(1'b1, int'(h));
        hold(1'b0, int'(l));
        add_period(h, l, w);
    endtask

    task automatic stop_main();
        en = 1'b0;
        hold(1'b0, 5);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({valid, stk_hi, stk_lo, ovr, period, high} !== '0) begin
            n_fail++;
            $display("FAIL reset_main: got v=%0b sh=%0b sl=%0b ov=%0b p=%0d h=%0d expected all 0",
                     valid, stk_hi, stk_lo, ovr, period, high);
        end
        n_checks++;
        if ({valid8, stk_hi8, stk_lo8, ovr8, period8, high8} !== '0) begin
            n_fail++;
            $display("FAIL reset_w8: got v=%0b p=%0d h=%0d expected all 0", valid8, period8, high8);
        end
    endtask

    task automatic test_basic();
        clear_q();
        timeout = 0; ready = 1'b1; en = 1'b1;
        hold(1'b0, 4);
        for (int i = 0; i < 5; i++) drive_period(30, 70, 32);
        hold(1'b1, 6);
        n_checks++;
        if (got_p.size() != exp_p.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d expected %0d", got_p.size(), exp_p.size());
        end
        for (int i = 0; i < got_p.size() && i < exp_p.size(); i++) begin
            n_checks++;
            if (got_p[i] !== exp_p[i] || got_h[i] !== exp_h[i]) begin
                n_fail++;
                $display("FAIL basic_meas[%0d]: got p=%0d h=%0d expected p=%0d h=%0d",
                         i, got_p[i], got_h[i], exp_p[i], exp_h[i]);
            end
        end
        n_checks++;
        if (ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_overrun: got %0b expected 0", ovr);
        end
        stop_main();
    endtask

    task automatic test_timeout();
        clear_q();
        timeout = 500; ready = 1'b1; en = 1'b1;
        for (int j = 1; j <= 510; j++) begin
            step(1'b0);
            if (j == 501 || j == 502 || j == 510) begin
                n_checks++;
                if (stk_lo !== (j >= 502) || stk_hi !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_stuck_low@%0d: got sl=%0b sh=%0b expected sl=%0b sh=0",
                             j, stk_lo, stk_hi, (j >= 502));
                end
            end
        end
        n_checks++;
        if (got_p.size() != 0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_no_valid: got %0d publishes valid=%0b expected none", got_p.size(), valid);
        end
        hold(1'b1, 20);
        n_checks++;
        if (stk_lo !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got %0b expected 0", stk_lo);
        end
        hold(1'b0, 30);
        add_period(20, 30, 32);
        drive_period(20, 30, 32);
        hold(1'b1, 6);
        n_checks++;
        if (got_p.size() != exp_p.size()) begin
            n_fail++;
            $display("FAIL timeout_count: got %0d expected %0d", got_p.size(), exp_p.size());
        end
        for (int i = 0; i < got_p.size() && i < exp_p.size(); i++) begin
            n_checks++;
            if (got_p[i] !== exp_p[i] || got_h[i] !== exp_h[i]) begin
                n_fail++;
                $display("FAIL timeout_meas[%0d]: got p=%0d h=%0d expected p=%0d h=%0d",
                         i, got_p[i], got_h[i], exp_p[i], exp_h[i]);
            end
        end
        timeout = 0;
        stop_main();
    endtask

    task automatic test_overrun();
        clear_q();
        timeout = 0; ready = 1'b0; en = 1'b1;
        hold(1'b0, 4);
        for (int i = 0; i < 3; i++) drive_period(10, 10, 32);
        hold(1'b1, 6);
        n_checks++;
        if (valid !== 1'b1 || period !== 32'(exp_p[0]) || high !== 32'(exp_h[0]) || ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_hold: got v=%0b p=%0d h=%0d ov=%0b expected v=1 p=%0d h=%0d ov=1",
                     valid, period, high, ovr, exp_p[0], exp_h[0]);
        end
        ready = 1'b1;
        step(1'b1);
        ready = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_accept: got v=%0b ov=%0b expected v=0 ov=1", valid, ovr);
        end
        n_checks++;
        if (got_p.size() != 1) begin
            n_fail++;
            $display("FAIL overrun_accept_count: got %0d expected 1", got_p.size());
        end
        stop_main();
    endtask

    task automatic test_saturation();
        clear_q();
        ready = 1'b1; en8 = 1'b1;
        hold(1'b0, 4);
        drive_period(300, 10, 8);
        drive_period(300, 10, 8);
        hold(1'b1, 6);
        n_checks++;
        if (got8_p.size() != exp_p.size()) begin
            n_fail++;
            $display("FAIL sat_count: got %0d expected %0d", got8_p.size(), exp_p.size());
        end
        for (int i = 0; i < got8_p.size() && i < exp_p.size(); i++) begin
            n_checks++;
            if (got8_p[i] !== exp_p[i] || got8_h[i] !== exp_h[i]) begin
                n_fail++;
                $display("FAIL sat_meas[%0d]: got p=%0d h=%0d expected p=%0d h=%0d",
                         i, got8_p[i], got8_h[i], exp_p[i], exp_h[i]);
            end
        end
        en8 = 1'b0;
        hold(1'b0, 5);
    endtask

    task automatic test_enable_drop();
        clear_q();
        timeout = 0; ready = 1'b0; en = 1'b1;
        hold(1'b0, 4);
        for (int i = 0; i < 3; i++) drive_period(10, 10, 32);
        hold(1'b1, 5);
        n_checks++;
        if (ovr !== 1'b1 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_pre: got v=%0b ov=%0b expected v=1 ov=1", valid, ovr);
        end
        en = 1'b0;
        hold(1'b1, 3);
        n_checks++;
        if ({valid, stk_hi, stk_lo, ovr, period, high} !== '0) begin
            n_fail++;
            $display("FAIL drop_clear: got v=%0b sh=%0b sl=%0b ov=%0b p=%0d h=%0d expected all 0",
                     valid, stk_hi, stk_lo, ovr, period, high);
        end
        hold(1'b0, 4);
        clear_q();
        ready = 1'b1; en = 1'b1;
        hold(1'b0, 4);
        drive_period(25, 15, 32);
        drive_period(25, 15, 32);
        hold(1'b1, 6);
        n_checks++;
        if (got_p.size() != exp_p.size()) begin
            n_fail++;
            $display("FAIL drop_count: got %0d expected %0d", got_p.size(), exp_p.size());
        end
        for (int i = 0; i < got_p.size() && i < exp_p.size(); i++) begin
            n_checks++;
            if (got_p[i] !== exp_p[i] || got_h[i] !== exp_h[i]) begin
                n_fail++;
                $display("FAIL drop_meas[%0d]: got p=%0d h=%0d expected p=%0d h=%0d",
                         i, got_p[i], got_h[i], exp_p[i], exp_h[i]);
            end
        end
        stop_main();
    endtask

    task automatic test_reset_mid();
        clear_q();
        timeout = 0; ready = 1'b0; en = 1'b1;
        hold(1'b0, 4);
        drive_period(20, 20, 32);
        hold(1'b1, 20);
        hold(1'b0, 10);
        n_checks++;
        if (valid !== 1'b1 || period !== 32'd40 || high !== 32'd20) begin
            n_fail++;
            $display("FAIL rstmid_pre: got v=%0b p=%0d h=%0d expected v=1 p=40 h=20", valid, period, high);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid, stk_hi, stk_lo, ovr, period, high} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got v=%0b p=%0d h=%0d ov=%0b expected all 0", valid, period, high, ovr);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
        ready = 1'b1;
        hold(1'b0, 4);
        drive_period(15, 5, 32);
        drive_period(15, 5, 32);
        hold(1'b1, 6);
        n_checks++;
        if (got_p.size() != exp_p.size()) begin
            n_fail++;
            $display("FAIL rstmid_count: got %0d expected %0d", got_p.size(), exp_p.size());
        end
        for (int i = 0; i < got_p.size() && i < exp_p.size(); i++) begin
            n_checks++;
            if (got_p[i] !== exp_p[i] || got_h[i] !== exp_h[i]) begin
                n_fail++;
                $display("FAIL rstmid_meas[%0d]: got p=%0d h=%0d expected p=%0d h=%0d",
                         i, got_p[i], got_h[i], exp_p[i], exp_h[i]);
            end
        end
        stop_main();
    endtask

    task automatic test_random();
        int unsigned h;
        int unsigned l;
        clear_q();
        timeout = 0; ready = 1'b1; en = 1'b1;
        hold(1'b0, 4);
        drive_period(1, 1, 32);
        drive_period(1, 2, 32);
        drive_period(2, 1, 32);
        for (int i = 0; i < 8; i++) begin
            h = $urandom_range(1, 40);
            l = $urandom_range(1, 40);
            drive_period(h, l, 32);
        end
        hold(1'b1, 6);
        n_checks++;
        if (got_p.size() != exp_p.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d expected %0d", got_p.size(), exp_p.size());
        end
        for (int i = 0; i < got_p.size() && i < exp_p.size(); i++) begin
            n_checks++;
            if (got_p[i] !== exp_p[i] || got_h[i] !== exp_h[i]) begin
                n_fail++;
                $display("FAIL random_meas[%0d]: got p=%0d h=%0d expected p=%0d h=%0d",
                         i, got_p[i], got_h[i], exp_p[i], exp_h[i]);
            end
        end
        n_checks++;
        if (ovr !== 1'b0 || stk_hi !== 1'b0 || stk_lo !== 1'b0) begin
            n_fail++;
            $display("FAIL random_flags: got ov=%0b sh=%0b sl=%0b expected 0", ovr, stk_hi, stk_lo);
        end
        stop_main();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; en8 = 1'b0; pwm = 1'b0; ready = 1'b0;
        timeout = 0; timeout8 = '0;
        #2;
        test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(1'b0, 2);
        test_basic();
        test_timeout();
        test_overrun();
        test_saturation();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
